regfile_sb: RTL and testbench



---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_scoreboard.sv | 54 +++++
 rtl/regfile_sb.sv | 81 ++++++++
 tb/tb_regfile_sb.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the integer register file and its write-pending scoreboard.
package regfile_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned DEF_CNT_W  = 6;
    localparam int unsigned REG_ZERO   = 0;

    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
    typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for issued-but-uncommitted destinations, plus a running busy count.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 iss_en_i,
    input  logic [ADDR_W-1:0]    iss_addr_i,
    input  logic                 wr_en_i,
    input  logic [ADDR_W-1:0]    wr_addr_i,
    output logic [2**ADDR_W-1:0] busy_o,
    output logic [CNT_W-1:0]     pending_cnt_o
);

    localparam int unsigned Depth = 2**ADDR_W;

    logic [Depth-1:0] busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             set, clr, inc, dec;

    always_comb begin
        set = iss_en_i && (iss_addr_i != ADDR_W'(REG_ZERO));
        clr = wr_en_i && (wr_addr_i != ADDR_W'(REG_ZERO));
        inc = set && !busy_q[iss_addr_i];
        // A re-issue of the register being committed keeps it busy, so nothing leaves.
        dec = clr && busy_q[wr_addr_i] && !(set && (iss_addr_i == wr_addr_i));

        busy_d = busy_q;
        if (clr) begin
            busy_d[wr_addr_i] = 1'b0;
        end
        if (set) begin
            busy_d[iss_addr_i] = 1'b1;
        end
        cnt_d = cnt_q + CNT_W'(inc) - CNT_W'(dec);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o        = busy_q;
    assign pending_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with two combinational read ports and a write-pending scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-through on reads and hazard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              hazard,
    output logic [CNT_W-1:0]  pending_cnt
);

    localparam int unsigned Depth = 2**ADDR_W;

    logic [DATA_W-1:0] mem_q [Depth];
    logic [Depth-1:0]  busy;
    logic [Depth-1:0]  busy_view;
    logic              wr_nz;

    assign wr_nz = wr_en && (wr_addr != ADDR_W'(REG_ZERO));

    // Entry 0 is never written, so it reads as zero without extra muxing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_nz) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    regfile_scoreboard #(
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .iss_en_i     (iss_en),
        .iss_addr_i   (iss_addr),
        .wr_en_i      (wr_en),
        .wr_addr_i    (wr_addr),
        .busy_o       (busy),
        .pending_cnt_o(pending_cnt)
    );

    always_comb begin
        rs_data   = mem_q[rs_addr];
        rt_data   = mem_q[rt_addr];
        busy_view = busy;
`ifdef REGFILE_BYPASS_EN
        if (wr_nz && rst_n) begin
            if (wr_addr == rs_addr) begin
                rs_data = wr_data;
            end
            if (wr_addr == rt_addr) begin
                rt_data = wr_data;
            end
            // A commit clears its busy bit early unless the same register is re-issued.
            if (!(iss_en && (iss_addr == wr_addr))) begin
                busy_view[wr_addr] = 1'b0;
            end
        end
`endif
        hazard = (busy_view[rs_addr] && (rs_addr != ADDR_W'(REG_ZERO))) ||
                 (busy_view[rt_addr] && (rt_addr != ADDR_W'(REG_ZERO)));
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard-style bench for regfile_sb: stimulus queues expectations, a negedge monitor checks them.
module tb_regfile_sb;
    import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    reg_addr_t   rs_addr = '0, rt_addr = '0, wr_addr = '0, iss_addr = '0;
    reg_data_t   rs_data, rt_data, wr_data = '0;
    logic        wr_en = 1'b0, iss_en = 1'b0, hazard;
    logic [5:0]  pending_cnt;

    regfile_sb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .iss_en     (iss_en),
        .iss_addr   (iss_addr),
        .hazard     (hazard),
        .pending_cnt(pending_cnt)
    );

    typedef struct {
        int          cyc;
        string       name;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        hz;
        logic [5:0]  cnt;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s.%s: got 0x%08h, want 0x%08h", nm, fld, act, req);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            mon_e = q.pop_front();
            if (mon_e.cyc < cyc) begin
                n_cmp++;
                n_err++;
                $display("FAIL %s.late: got cycle %0d, want cycle %0d", mon_e.name, cyc, mon_e.cyc);
            end else begin
                chk(mon_e.name, "rs_data", rs_data, mon_e.rs);
                chk(mon_e.name, "rt_data", rt_data, mon_e.rt);
                chk(mon_e.name, "hazard", 32'(hazard), 32'(mon_e.hz));
                chk(mon_e.name, "pending_cnt", 32'(pending_cnt), 32'(mon_e.cnt));
            end
        end
    end

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic ie, input logic [4:0] ia,
                         input logic [4:0] ra, input logic [4:0] rb);
        @(posedge clk);
        #1;
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        iss_en   = ie;
        iss_addr = ia;
        rs_addr  = ra;
        rt_addr  = rb;
    endtask

    task automatic expect_out(input string nm, input logic [31:0] ers, input logic [31:0] ert,
                              input logic ehz, input logic [5:0] ecnt);
        exp_t e;
        e.cyc  = cyc;
        e.name = nm;
        e.rs   = ers;
        e.rt   = ert;
        e.hz   = ehz;
        e.cnt  = ecnt;
        q.push_back(e);
    endtask

    initial begin
        // Held in reset with zero inputs
        drive(0, 0, 0, 0, 0, 5, 7);
        expect_out("in_reset", 0, 0, 0, 0);
        for (int a = 0; a < 32; a++) begin
            drive(0, 0, 0, 0, 0, 5'(a), 5'(31 - a));
            if (a == 0) rst_n = 1'b1;
            expect_out($sformatf("rst_rd%0d", a), 0, 0, 0, 0);
        end

        drive(1, 5, 32'hDEADBEEF, 0, 0, 5, 0);
        expect_out("wr5_same", BYP ? 32'hDEADBEEF : 32'h0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 5, 0);
        expect_out("rd5", 32'hDEADBEEF, 0, 0, 0);
        drive(1, 0, 32'h12345678, 0, 0, 0, 0);
        expect_out("wr0_same", 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 5);
        expect_out("rd0_rd5", 0, 32'hDEADBEEF, 0, 0);

        drive(0, 0, 0, 1, 7, 7, 0);
        expect_out("iss7", 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 7, 0);
        expect_out("busy7", 0, 0, 1, 1);
        drive(1, 7, 32'hA5, 0, 0, 7, 0);
        expect_out("wr7_same", BYP ? 32'hA5 : 32'h0, 0, !BYP, 1);
        drive(0, 0, 0, 0, 0, 7, 0);
        expect_out("rd7", 32'hA5, 0, 0, 0);

        drive(1, 9, 32'h55, 1, 9, 9, 0);
        expect_out("isswr9", BYP ? 32'h55 : 32'h0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 9, 0);
        expect_out("busy9", 32'h55, 0, 1, 1);
        drive(1, 9, 32'h66, 1, 9, 9, 0);
        expect_out("isswr9_busy", BYP ? 32'h66 : 32'h55, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 9, 0);
        expect_out("still9", 32'h66, 0, 1, 1);

        drive(0, 0, 0, 1, 4, 0, 0);
        expect_out("iss4", 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        expect_out("cnt2", 0, 0, 0, 2);
        drive(1, 4, 32'h44, 1, 3, 4, 3);
        expect_out("iss3_wr4", BYP ? 32'h44 : 32'h0, 0, !BYP, 2);
        drive(0, 0, 0, 0, 0, 4, 3);
        expect_out("net0", 32'h44, 0, 1, 2);

        drive(1, 9, 32'h99, 0, 0, 9, 3);
        expect_out("wr9", BYP ? 32'h99 : 32'h66, 0, 1, 2);
        drive(1, 3, 32'h33, 0, 0, 9, 3);
        expect_out("wr3", 32'h99, BYP ? 32'h33 : 32'h0, !BYP, 1);
        drive(0, 0, 0, 0, 0, 9, 3);
        expect_out("clr_all", 32'h99, 32'h33, 0, 0);

        drive(0, 0, 0, 1, 10, 10, 0);
        expect_out("iss10", 0, 0, 0, 0);
        drive(1, 10, 32'hCAFE, 0, 0, 10, 0);
        expect_out("wr10_byp", BYP ? 32'hCAFE : 32'h0, 0, !BYP, 1);
        drive(0, 0, 0, 0, 0, 10, 0);
        expect_out("rd10", 32'hCAFE, 0, 0, 0);
        drive(1, 10, 32'h0BAD, 0, 0, 10, 0);
        expect_out("wr10_idle", BYP ? 32'h0BAD : 32'hCAFE, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 10, 0);
        expect_out("no_underflow", 32'h0BAD, 0, 0, 0);

        for (int i = 1; i < 32; i++) begin
            drive(0, 0, 0, 1, 5'(i), 0, 0);
            expect_out($sformatf("fill%0d", i), 0, 0, 0, 6'(i - 1));
        end
        drive(0, 0, 0, 0, 0, 1, 31);
        expect_out("full", 0, 0, 1, 31);
        drive(0, 0, 0, 1, 1, 1, 0);
        expect_out("reiss1", 0, 0, 1, 31);
        drive(0, 0, 0, 0, 0, 0, 0);
        expect_out("reiss_hold", 0, 0, 0, 31);
        drive(1, 0, 32'hFF, 0, 0, 0, 31);
        expect_out("wr0_busy", 0, 0, 1, 31);
        drive(0, 0, 0, 0, 0, 0, 0);
        expect_out("wr0_hold", 0, 0, 0, 31);
        drive(0, 0, 0, 1, 2, 5, 7);
        expect_out("pre_reset", 32'hDEADBEEF, 32'hA5, 1, 31);

        // Mid-operation reset must clear state before the next edge
        drive(0, 0, 0, 1, 6, 5, 7);
        rst_n = 1'b0;
        expect_out("mid_reset", 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 5, 7);
        rst_n = 1'b1;
        expect_out("post_reset", 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 6, 2);
        expect_out("discarded", 0, 0, 0, 0);

        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
